// File: rtl/univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : univ_shift_reg
// Description : Parametrised universal shift register. Run-time selectable
//               hold / shift-left / shift-right / parallel-load with clock
//               enable, serial taps at both ends, a saturating shift counter
//               and a one-cycle frame_done pulse after a full WIDTH-bit frame.
// Revision    : 1.0 - initial release
// ============================================================================
module univ_shift_reg #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
    localparam int              CW        = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic             sin_r,
    input  logic             sin_l,
    input  logic [WIDTH-1:0] pdin,
    output logic [WIDTH-1:0] q,
    output logic             sout_l,
    output logic             sout_r,
    output logic [CW-1:0]    cnt,
    output logic             frame_done
);

    // Operation encodings on the mode input
    localparam logic [1:0] C_MODE_HOLD  = 2'b00;
    localparam logic [1:0] C_MODE_LEFT  = 2'b01;
    localparam logic [1:0] C_MODE_RIGHT = 2'b10;
    localparam logic [1:0] C_MODE_LOAD  = 2'b11;

    // Counter limits: saturation value and the value that precedes the pulse
    localparam logic [CW-1:0] C_CNT_FULL = CW'(WIDTH);
    localparam logic [CW-1:0] C_CNT_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] r_q;
    logic [CW-1:0]    r_cnt;
    logic             r_frame_done;

    logic [WIDTH-1:0] w_q_next;
    logic [CW-1:0]    w_cnt_next;
    logic             w_frame_done_next;
    logic             w_is_shift;

    // A shift is any enabled left or right move; both feed the same counter
    assign w_is_shift = en && ((mode == C_MODE_LEFT) || (mode == C_MODE_RIGHT));

    // Next-state selection for data, counter and frame pulse
    always_comb begin
        w_q_next          = r_q;
        w_cnt_next        = r_cnt;
        w_frame_done_next = 1'b0;
        if (en) begin
            case (mode)
                C_MODE_HOLD: begin
                    w_q_next = r_q;
                end
                C_MODE_LEFT: begin
                    w_q_next = {r_q[WIDTH-2:0], sin_r};
                end
                C_MODE_RIGHT: begin
                    w_q_next = {sin_l, r_q[WIDTH-1:1]};
                end
                C_MODE_LOAD: begin
                    w_q_next   = pdin;
                    w_cnt_next = '0;
                end
                default: begin
                    w_q_next = r_q;
                end
            endcase
            if (w_is_shift) begin
                // Saturate at WIDTH so the pulse cannot recur without a load
                if (r_cnt != C_CNT_FULL) begin
                    w_cnt_next = r_cnt + 1'b1;
                end
                w_frame_done_next = (r_cnt == C_CNT_LAST);
            end
        end
    end

    // State registers with asynchronous reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q          <= RESET_VAL;
            r_cnt        <= '0;
            r_frame_done <= 1'b0;
        end else begin
            r_q          <= w_q_next;
            r_cnt        <= w_cnt_next;
            r_frame_done <= w_frame_done_next;
        end
    end

    assign q          = r_q;
    assign cnt        = r_cnt;
    assign frame_done = r_frame_done;

    // Serial taps come straight from the register, no extra stage
    assign sout_l = r_q[WIDTH-1];
    assign sout_r = r_q[0];

endmodule
`default_nettype wire

// File: tb/tb_univ_shift_reg.sv
`default_nettype none
// ============================================================================
// Module      : tb_univ_shift_reg
// Description : Scoreboard bench for univ_shift_reg (WIDTH=8, RESET_VAL=0).
//               Driver pushes expected results from an arithmetic model into
//               a queue; a monitor pops and compares after every edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_univ_shift_reg;

    localparam int WIDTH = 8;
    localparam int CW    = 4;

    logic             clk;
    logic             rst;
    logic             en;
    logic [1:0]       mode;
    logic             sin_r;
    logic             sin_l;
    logic [WIDTH-1:0] pdin;
    logic [WIDTH-1:0] q;
    logic             sout_l;
    logic             sout_r;
    logic [CW-1:0]    cnt;
    logic             frame_done;

    univ_shift_reg #(
        .WIDTH     (WIDTH),
        .RESET_VAL (8'h00)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .mode       (mode),
        .sin_r      (sin_r),
        .sin_l      (sin_l),
        .pdin       (pdin),
        .q          (q),
        .sout_l     (sout_l),
        .sout_r     (sout_r),
        .cnt        (cnt),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int q;
        int cnt;
        int fd;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;

    // Reference model: value as an integer plus an unbounded shift count
    int m_q      = 0;
    int m_shifts = 0;

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every edge with a pending expectation gets compared
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("q",          int'(q),          e.q);
            check("cnt",        int'(cnt),        e.cnt);
            check("frame_done", int'(frame_done), e.fd);
            check("sout_l",     int'(sout_l),     (e.q >> 7) & 1);
            check("sout_r",     int'(sout_r),     e.q & 1);
        end
    end

    // One enabled/disabled cycle: model it, queue the expectation, clock it
    task automatic step(input logic e_en, input logic [1:0] e_mode,
                        input logic e_sr, input logic e_sl, input logic [7:0] e_pd);
        exp_t x;
        int   fd;
        en    = e_en;
        mode  = e_mode;
        sin_r = e_sr;
        sin_l = e_sl;
        pdin  = e_pd;
        fd    = 0;
        if (e_en) begin
            if (e_mode == 2'd1) begin
                m_q = ((m_q * 2) + int'(e_sr)) % 256;
                m_shifts++;
                fd = (m_shifts == WIDTH) ? 1 : 0;
            end else if (e_mode == 2'd2) begin
                m_q = (m_q / 2) + (int'(e_sl) * 128);
                m_shifts++;
                fd = (m_shifts == WIDTH) ? 1 : 0;
            end else if (e_mode == 2'd3) begin
                m_q      = int'(e_pd);
                m_shifts = 0;
            end
        end
        x.q   = m_q;
        x.cnt = (m_shifts > WIDTH) ? WIDTH : m_shifts;
        x.fd  = fd;
        sb_q.push_back(x);
        @(posedge clk);
        #2;
    endtask

    // Mid-cycle reset: checked before any edge, then held over one edge
    task automatic pulse_reset();
        rst = 1'b1;
        #1;
        check("rst_q",   int'(q),          0);
        check("rst_cnt", int'(cnt),        0);
        check("rst_fd",  int'(frame_done), 0);
        m_q      = 0;
        m_shifts = 0;
        en   = 1'b1;
        mode = 2'd3;
        pdin = 8'hFF;
        @(posedge clk);
        #2;
        check("rst_hold_q", int'(q), 0);
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pat;
        rst = 1'b1; en = 1'b0; mode = 2'd0; sin_r = 1'b0; sin_l = 1'b0; pdin = 8'h00;
        repeat (2) @(posedge clk);
        #2;
        rst = 1'b0;

        // Scenario: load, then reset between edges
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h5A);
        pulse_reset();

        // Scenario: parallel load
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
        check("load_q", int'(q), 8'hA5);
        check("load_souts", int'({sout_l, sout_r}), 3);

        // Scenario: SIPO frame from reset, then one extra shift
        pulse_reset();
        pat = 8'b1011_0010;
        for (int i = 7; i >= 0; i--) step(1'b1, 2'd1, pat[i], 1'b0, 8'h00);
        check("sipo_q", int'(q), 8'hB2);
        check("sipo_fd", int'(frame_done), 1);
        step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
        check("sat_cnt", int'(cnt), 8);
        check("sat_fd", int'(frame_done), 0);

        // Scenario: shift right with sin_l=0
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'hA5);
        for (int i = 0; i < 3; i++) step(1'b1, 2'd2, 1'b1, 1'b0, 8'h00);
        check("shr_q", int'(q), 8'h14);
        check("shr_cnt", int'(cnt), 3);

        // Scenario: enable low beats load, then hold
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h3C);
        step(1'b0, 2'd3, 1'b0, 1'b0, 8'hFF);
        step(1'b0, 2'd3, 1'b0, 1'b0, 8'hFF);
        check("en0_q", int'(q), 8'h3C);
        step(1'b1, 2'd0, 1'b1, 1'b1, 8'hFF);
        check("hold_q", int'(q), 8'h3C);

        // Scenario: reset discards a partial frame
        step(1'b1, 2'd3, 1'b0, 1'b0, 8'h00);
        for (int i = 0; i < 5; i++) step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
        check("part_q", int'(q), 8'h1F);
        pulse_reset();
        for (int i = 0; i < 8; i++) begin
            step(1'b1, 2'd1, 1'b1, 1'b0, 8'h00);
            if (i == 2) check("no_early_fd", int'(frame_done), 0);
        end
        check("late_fd", int'(frame_done), 1);

        // Randomised mix of all operations, enables and resets
        for (int n = 0; n < 600; n++) begin
            int r;
            logic [1:0] md;
            r = int'($urandom_range(0, 15));
            if (r == 0)      md = 2'd3;
            else if (r < 3)  md = 2'd0;
            else if (r < 10) md = 2'd1;
            else             md = 2'd2;
            if ($urandom_range(0, 59) == 0) pulse_reset();
            step(($urandom_range(0, 7) != 0), md, 1'($urandom), 1'($urandom), 8'($urandom));
        end

        @(posedge clk);
        #2;
        check("queue_drained", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
